move_exec_unit: RTL and testbench
=================================

// Module: move_exec_unit
// PURPOSE
//  Execution stage directly downstream of the opcode decoder. Consumes the decoder's start_move / start_movi
//  strobes plus latched operand fields and performs the register-file transfer: MOVE copies rs->rd,
//  MOVI writes an immediate to rd. Multi-cycle FSM with busy/done handshake back to the CPU control sequencer.
// PARAMETERS
//  DATA_W      16  register-file data width
//  REG_ADDR_W  3   register index width (8 registers)
//  IMM_W       8   immediate field width; IMM_W <= DATA_W required
// PORTS
//  clk         in   1           system clock, all state updates on rising edge
//  rst_n       in   1           synchronous active-low reset, sampled on rising edge of clk
//  start_move  in   1           decoder strobe: execute MOVE
//  start_movi  in   1           decoder strobe: execute MOVI
//  rd          in   REG_ADDR_W  destination register index
//  rs          in   REG_ADDR_W  source register index (MOVE only)
//  imm         in   IMM_W       immediate value (MOVI only)
//  rf_rd_addr  out  REG_ADDR_W  register-file read address
//  rf_rd_data  in   DATA_W      register-file read data, 1-cycle synchronous read latency
//  rf_we       out  1           register-file write enable
//  rf_wr_addr  out  REG_ADDR_W  register-file write address
//  rf_wr_data  out  DATA_W      register-file write data
//  busy        out  1           high in any state other than IDLE
//  done        out  1           one-cycle pulse on completion
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rf_we=0, done=0, busy=0, rf_rd_addr=0, rf_wr_addr=0,
//    rf_wr_data=0, armed=1. Reset mid-operation aborts immediately; no write is issued afterwards.
//  - States: IDLE, READ, WRITE, DONE. busy = (state != IDLE).
//  - Accept: in IDLE at a posedge with armed=1 and (start_move | start_movi): latch rd/rs/imm, clear armed.
//    start_move -> READ; start_movi -> WRITE with rf_wr_data = extended imm.
//  - Both strobes high at accept: MOVE wins, MOVI ignored (decoder never issues both; not an error).
//  - Re-arm: armed sets at any posedge where start_move=0 and start_movi=0. A strobe held high across
//    several edges launches exactly one operation. Strobes outside IDLE are ignored (no queueing).
//  - READ (1 cycle): rf_rd_addr = latched rs; next posedge captures rf_rd_data into rf_wr_data -> WRITE.
//  - WRITE (1 cycle): rf_we=1, rf_wr_addr = latched rd, rf_wr_data as above -> DONE.
//  - DONE (1 cycle): done=1, rf_we=0 -> IDLE.
//  - Latency from accepting edge: MOVE rf_we in cycle 2, done in cycle 3; MOVI rf_we in cycle 1,
//    done in cycle 2. Earliest next accept: the edge ending DONE, provided armed.
//  - rd==rs legal: value rewritten unchanged. rf_we never high for more than one cycle per operation.
//  - All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  MOVI_SIGN_EXT_EN defined: MOVI data = imm sign-extended to DATA_W (imm[IMM_W-1] replicated).
//  Not defined (default): MOVI data = imm zero-extended to DATA_W. MOVE path unaffected either way.
// TESTING
//  1 MOVI: rd=3, imm=8'h5A, start_movi 1 cycle -> rf_we=1 addr 3 data 16'h005A cycle 1; done cycle 2.
//  2 MOVE: rf[5]=16'hBEEF, rs=5, rd=2, start_move -> rf_rd_addr=5 cycle 1; rf_we addr 2 data BEEF
//    cycle 2; done cycle 3; busy high cycles 1-3.
//  3 Hold start_movi high 6 cycles -> exactly one rf_we pulse; drop low 1 cycle, re-raise -> second op.
//  4 imm=8'h80: without MOVI_SIGN_EXT_EN -> data 16'h0080; with MOVI_SIGN_EXT_EN -> 16'hFF80.
//  5 start_move and start_movi together, rs=1 rd=4 -> MOVE executes (rf_rd_addr=1), no immediate write.
//  6 rst_n=0 during READ of a MOVE -> next cycle IDLE, busy=0, no rf_we pulse, no done pulse.

Source files
------------

// File: rtl/move_exec_unit_if.sv
// move_exec_unit_if: decoder strobes, operand fields, register-file port and busy/done handshake
interface move_exec_unit_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8
);
    logic                  start_move;
    logic                  start_movi;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0]     rf_rd_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0]     rf_wr_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start_move, start_movi, rd, rs, imm, rf_rd_data,
        input  rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data, busy, done
    );

    modport slave (
        input  start_move, start_movi, rd, rs, imm, rf_rd_data,
        output rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data, busy, done
    );
endinterface

// File: rtl/move_exec_unit.sv
// move_exec_unit: MOVE/MOVI register-file transfer FSM; MOVI_SIGN_EXT_EN selects sign- instead of zero-extension
module move_exec_unit #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8
) (
    input logic             clk,
    input logic             rst_n,
    move_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    logic                  armed;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     imm_ext;

`ifdef MOVI_SIGN_EXT_EN
    assign imm_ext = DATA_W'($signed(bus.imm));
`else
    assign imm_ext = DATA_W'(bus.imm);
`endif

    // Sequencer: accept a strobe once per assertion, read source, write destination, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            armed           <= 1'b1;
            rd_q            <= '0;
            bus.rf_we       <= 1'b0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.rf_rd_addr  <= '0;
            bus.rf_wr_addr  <= '0;
            bus.rf_wr_data  <= '0;
        end else begin
            bus.rf_we <= 1'b0;
            bus.done  <= 1'b0;
            if (!bus.start_move && !bus.start_movi)
                armed <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (armed && (bus.start_move || bus.start_movi)) begin
                        armed    <= 1'b0;
                        rd_q     <= bus.rd;
                        bus.busy <= 1'b1;
                        if (bus.start_move) begin
                            state          <= READ;
                            bus.rf_rd_addr <= bus.rs;
                        end else begin
                            state          <= WRITE;
                            bus.rf_we      <= 1'b1;
                            bus.rf_wr_addr <= bus.rd;
                            bus.rf_wr_data <= imm_ext;
                        end
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                READ: begin
                    state          <= WRITE;
                    bus.rf_we      <= 1'b1;
                    bus.rf_wr_addr <= rd_q;
                    bus.rf_wr_data <= bus.rf_rd_data;
                end
                WRITE: begin
                    state    <= DONE;
                    bus.done <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_exec_unit.sv
// tb_move_exec_unit: scoreboarded bench for move_exec_unit with a register-file model
module tb_move_exec_unit;
    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] rf [8];
    wr_t exp_q [$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    move_exec_unit_if bus ();
    move_exec_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Register file: read data follows the registered read address, writes land on the edge
    assign bus.rf_rd_data = rf[bus.rf_rd_addr];
    always @(posedge clk) if (bus.rf_we === 1'b1) rf[bus.rf_wr_addr] <= bus.rf_wr_data;

    // Write monitor: every write must match the next expected entry and last exactly one cycle
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", bus.rf_wr_addr, bus.rf_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rf_wr_addr, bus.rf_wr_data} !== e) begin
                    errors++;
                    $display("FAIL write_mismatch: addr %0d data %h, required addr %0d data %h", bus.rf_wr_addr, bus.rf_wr_data, e.addr, e.data);
                end
            end
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width: rf_we high 2 consecutive cycles, required 1");
            end
        end
        if (bus.done === 1'b1) done_cnt++;
        prev_we = (bus.rf_we === 1'b1);
    end

    function automatic logic [15:0] ext(input logic [7:0] v);
`ifdef MOVI_SIGN_EXT_EN
        return {{8{v[7]}}, v};
`else
        return {8'h00, v};
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, bus.done, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.rf_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/we=%b, required 000", {bus.busy, bus.done, bus.rf_we});
        end
        checks++;
        if ({bus.rf_rd_addr, bus.rf_wr_addr} !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr: rd_addr %0d wr_addr %0d, required 0 0", bus.rf_rd_addr, bus.rf_wr_addr);
        end
        checks++;
        if (bus.rf_wr_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_wr_data: %h, required 0000", bus.rf_wr_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_movi;
        bus.rd = 3'd3;
        bus.imm = 8'h5A;
        bus.start_movi = 1'b1;
        exp_q.push_back({3'd3, 16'h005A});
        tick();
        bus.start_movi = 1'b0;
        checks++;
        if ({bus.rf_we, bus.rf_wr_addr, bus.rf_wr_data} !== {1'b1, 3'd3, 16'h005A}) begin
            errors++;
            $display("FAIL movi_c1_write: we %b addr %0d data %h, required 1 3 005A", bus.rf_we, bus.rf_wr_addr, bus.rf_wr_data);
        end
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL movi_c1_flags: busy/done=%b, required 10", {bus.busy, bus.done});
        end
        tick();
        checks++;
        if ({bus.done, bus.rf_we} !== 2'b10) begin
            errors++;
            $display("FAIL movi_c2_done: done/we=%b, required 10", {bus.done, bus.rf_we});
        end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL movi_c3_idle: busy/done=%b, required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_move;
        rf[5] = 16'hBEEF;
        bus.rs = 3'd5;
        bus.rd = 3'd2;
        bus.start_move = 1'b1;
        exp_q.push_back({3'd2, 16'hBEEF});
        tick();
        bus.start_move = 1'b0;
        checks++;
        if ({bus.rf_rd_addr, bus.rf_we, bus.busy} !== {3'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL move_c1_read: rd_addr %0d we %b busy %b, required 5 0 1", bus.rf_rd_addr, bus.rf_we, bus.busy);
        end
        tick();
        checks++;
        if ({bus.rf_we, bus.rf_wr_addr, bus.rf_wr_data, bus.busy} !== {1'b1, 3'd2, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL move_c2_write: we %b addr %0d data %h busy %b, required 1 2 BEEF 1", bus.rf_we, bus.rf_wr_addr, bus.rf_wr_data, bus.busy);
        end
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.rf_we} !== 3'b110) begin
            errors++;
            $display("FAIL move_c3_done: done/busy/we=%b, required 110", {bus.done, bus.busy, bus.rf_we});
        end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL move_c4_idle: busy/done=%b, required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_hold;
        int w0 = we_cnt;
        bus.rd = 3'd6;
        bus.imm = 8'h11;
        bus.start_movi = 1'b1;
        exp_q.push_back({3'd6, 16'h0011});
        repeat (6) tick();
        checks++;
        if (we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL hold_single_op: %0d writes, required 1", we_cnt - w0);
        end
        bus.start_movi = 1'b0;
        tick();
        bus.rd = 3'd7;
        bus.imm = 8'h22;
        bus.start_movi = 1'b1;
        exp_q.push_back({3'd7, 16'h0022});
        tick();
        bus.start_movi = 1'b0;
        wait_done("hold_rearm");
        tick();
        checks++;
        if (we_cnt - w0 != 2) begin
            errors++;
            $display("FAIL hold_rearm: %0d writes, required 2", we_cnt - w0);
        end
    endtask

    task automatic test_sign;
        bus.rd = 3'd1;
        bus.imm = 8'h80;
        bus.start_movi = 1'b1;
        exp_q.push_back({3'd1, ext(8'h80)});
        tick();
        bus.start_movi = 1'b0;
        checks++;
        if (bus.rf_wr_data !== ext(8'h80)) begin
            errors++;
            $display("FAIL imm_extend: data %h, required %h", bus.rf_wr_data, ext(8'h80));
        end
        wait_done("imm_extend");
        tick();
    endtask

    task automatic test_both;
        rf[1] = 16'h1234;
        bus.rs = 3'd1;
        bus.rd = 3'd4;
        bus.imm = 8'hEE;
        bus.start_move = 1'b1;
        bus.start_movi = 1'b1;
        exp_q.push_back({3'd4, 16'h1234});
        tick();
        bus.start_move = 1'b0;
        bus.start_movi = 1'b0;
        checks++;
        if ({bus.rf_rd_addr, bus.rf_we} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL both_move_wins: rd_addr %0d we %b, required 1 0", bus.rf_rd_addr, bus.rf_we);
        end
        wait_done("both");
        tick();
    endtask

    task automatic test_reset_mid;
        int w0 = we_cnt;
        int d0 = done_cnt;
        bus.rs = 3'd5;
        bus.rd = 3'd7;
        bus.start_move = 1'b1;
        tick();
        bus.start_move = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_read: busy %b, required 1", bus.busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.rf_we, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: busy/we/done=%b, required 000", {bus.busy, bus.rf_we, bus.done});
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (we_cnt != w0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_effect: %0d writes %0d dones, required 0 0", we_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] rs_v = 3'($urandom_range(0, 7));
            logic [2:0] rd_v = 3'($urandom_range(0, 7));
            logic [7:0] imm_v = 8'($urandom_range(0, 255));
            bus.rs = rs_v;
            bus.rd = rd_v;
            bus.imm = imm_v;
            if ($urandom_range(0, 1) == 1) begin
                exp_q.push_back({rd_v, rf[rs_v]});
                bus.start_move = 1'b1;
            end else begin
                exp_q.push_back({rd_v, ext(imm_v)});
                bus.start_movi = 1'b1;
            end
            tick();
            bus.start_move = 1'b0;
            bus.start_movi = 1'b0;
            wait_done("back_to_back");
            tick();
        end
    endtask

    initial begin
        bus.start_move = 1'b0;
        bus.start_movi = 1'b0;
        bus.rd = '0;
        bus.rs = '0;
        bus.imm = '0;
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i);
        test_reset();
        test_movi();
        test_move();
        test_hold();
        test_sign();
        test_both();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
